// File: rtl/cpu_muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, counter width.
package cpu_muldiv_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hilo_unsigned_fix.sv
// Converts the signed 32x32 product into the unsigned product when uns is set.
// A negative-looking operand contributes an extra (other operand << 32) term.
module hilo_unsigned_fix
  import cpu_muldiv_pkg::*;
(
  input  logic [63:0] mul_z,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  input  logic        uns,
  output logic [63:0] prod
);

  logic [63:0] fix_a;
  logic [63:0] fix_b;

  // Correction terms, all arithmetic modulo 2^64.
  always_comb begin
    fix_a = 64'd0;
    fix_b = 64'd0;
    if (uns && mul_a[31]) fix_a = {mul_b, 32'd0};
    if (uns && mul_b[31]) fix_b = {mul_a, 32'd0};
    prod = mul_z + fix_a + fix_b;
  end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// Multi-cycle issue controller and HI/LO register pair behind the
// combinational 32x32 signed multiplier.
module hilo_mul_ctrl
  import cpu_muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  // Settle time must fit the down-counter and be at least one cycle.
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("hilo_mul_ctrl: MUL_LAT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              uns;
  logic [63:0]       prod;

  hilo_unsigned_fix u_fix (
    .mul_z (mul_z),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .uns   (uns),
    .prod  (prod)
  );

  // Handshake and stall flags derived from the state register.
  assign op_ready = (state == IDLE) && !reset;
  assign busy     = (state == WAIT);

  // Issue FSM, operand registers and HI/LO pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      mul_a <= 32'd0;
      mul_b <= 32'd0;
      cnt   <= '0;
      uns   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULT, OP_MULTU: begin
                mul_a <= rs_val;
                mul_b <= rt_val;
                uns   <= (op_code == OP_MULTU);
                cnt   <= CNT_INIT;
                state <= WAIT;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl: three instances at MUL_LAT = 2, 3 and 1,
// each fed by a behavioural signed 32x32 multiplier.
module tb_hilo_mul_ctrl;

  logic        clk;
  logic        reset    [3];
  logic        op_valid [3];
  logic [2:0]  op_code  [3];
  logic [31:0] rs_val   [3];
  logic [31:0] rt_val   [3];
  logic        op_ready [3];
  logic [31:0] mul_a    [3];
  logic [31:0] mul_b    [3];
  logic [63:0] mul_z    [3];
  logic [31:0] hi       [3];
  logic [31:0] lo       [3];
  logic        busy     [3];
  logic        done     [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = $signed({{32{a[31]}}, a});
    eb = $signed({{32{b[31]}}, b});
    return 64'(ea * eb);
  endfunction

  assign mul_z[0] = smul(mul_a[0], mul_b[0]);
  assign mul_z[1] = smul(mul_a[1], mul_b[1]);
  assign mul_z[2] = smul(mul_a[2], mul_b[2]);

  hilo_mul_ctrl #(.MUL_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset[0]), .op_valid(op_valid[0]), .op_code(op_code[0]),
    .rs_val(rs_val[0]), .rt_val(rt_val[0]), .op_ready(op_ready[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_z(mul_z[0]),
    .hi(hi[0]), .lo(lo[0]), .busy(busy[0]), .done(done[0])
  );

  hilo_mul_ctrl #(.MUL_LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset[1]), .op_valid(op_valid[1]), .op_code(op_code[1]),
    .rs_val(rs_val[1]), .rt_val(rt_val[1]), .op_ready(op_ready[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_z(mul_z[1]),
    .hi(hi[1]), .lo(lo[1]), .busy(busy[1]), .done(done[1])
  );

  hilo_mul_ctrl #(.MUL_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset[2]), .op_valid(op_valid[2]), .op_code(op_code[2]),
    .rs_val(rs_val[2]), .rt_val(rt_val[2]), .op_ready(op_ready[2]),
    .mul_a(mul_a[2]), .mul_b(mul_b[2]), .mul_z(mul_z[2]),
    .hi(hi[2]), .lo(lo[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [2:0] code,
                       input logic [31:0] rs, input logic [31:0] rt);
    op_valid[i] = v;
    op_code[i]  = code;
    rs_val[i]   = rs;
    rt_val[i]   = rt;
  endtask

  task automatic chk_hilo(input string tag, input int i, input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_hi"}, 64'(hi[i]), 64'(eh));
    chk({tag, "_lo"}, 64'(lo[i]), 64'(el));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1;
      drive(i, 1'b0, 3'd0, 32'd0, 32'd0);
    end
    step();
    step();

    // Reset state on every instance.
    for (int i = 0; i < 3; i++) begin
      chk("rst_op_ready", 64'(op_ready[i]), 64'd0);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_done", 64'(done[i]), 64'd0);
      chk("rst_mul_a", 64'(mul_a[i]), 64'd0);
      chk_hilo("rst", i, 32'd0, 32'd0);
    end
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("ready_after_rst", 64'(op_ready[i]), 64'd1);

    // ---------------- MUL_LAT = 2 ----------------
    drive(0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    step();                                     // edge T accepts MULT
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("mult_busy_t1", 64'(busy[0]), 64'd1);
    chk("mult_ready_t1", 64'(op_ready[0]), 64'd0);
    chk("mult_mul_a", 64'(mul_a[0]), 64'hFFFF_FFFE);
    chk("mult_mul_b", 64'(mul_b[0]), 64'h0000_0003);
    step();                                     // T+1
    chk("mult_busy_t2", 64'(busy[0]), 64'd1);
    chk("mult_done_t2", 64'(done[0]), 64'd0);
    chk_hilo("mult_not_yet", 0, 32'd0, 32'd0);
    step();                                     // T+2 commit
    chk_hilo("mult_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("mult_busy_done", 64'(busy[0]), 64'd0);
    chk("mult_done_pulse", 64'(done[0]), 64'd1);
    step();
    chk("mult_done_clear", 64'(done[0]), 64'd0);
    chk("mul_a_hold", 64'(mul_a[0]), 64'hFFFF_FFFE);

    // MULTU and MULT of all-ones operands.
    drive(0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    step();
    step();
    chk_hilo("multu_ones", 0, 32'hFFFF_FFFE, 32'h0000_0001);
    drive(0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    step();
    step();
    chk_hilo("mult_ones", 0, 32'h0000_0000, 32'h0000_0001);

    // MTHI then MTLO.
    drive(0, 1'b1, 3'd3, 32'h1234_5678, 32'd0);
    step();
    chk_hilo("mthi", 0, 32'h1234_5678, 32'h0000_0001);
    chk("mthi_busy", 64'(busy[0]), 64'd0);
    drive(0, 1'b1, 3'd4, 32'hCAFE_F00D, 32'd0);
    step();
    chk_hilo("mtlo", 0, 32'h1234_5678, 32'hCAFE_F00D);

    // Reserved op code behaves as NOP.
    drive(0, 1'b1, 3'd5, 32'h5555_5555, 32'h6666_6666);
    step();
    chk_hilo("nop5", 0, 32'h1234_5678, 32'hCAFE_F00D);
    chk("nop5_busy", 64'(busy[0]), 64'd0);
    chk("nop5_mul_a", 64'(mul_a[0]), 64'hFFFF_FFFF);

    // MULT followed by an MTLO held during WAIT.
    drive(0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    step();                                     // T
    drive(0, 1'b1, 3'd4, 32'h0000_DEAD, 32'd0);
    chk("held_ready_t1", 64'(op_ready[0]), 64'd0);
    chk("held_lo_t1", 64'(lo[0]), 64'hCAFE_F00D);
    step();                                     // T+1
    chk("held_lo_t2", 64'(lo[0]), 64'hCAFE_F00D);
    step();                                     // T+2 commit
    chk_hilo("held_commit", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("held_ready_commit", 64'(op_ready[0]), 64'd1);
    step();                                     // MTLO accepted
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk_hilo("held_mtlo", 0, 32'hFFFF_FFFF, 32'h0000_DEAD);

    // ---------------- MUL_LAT = 3: reset mid-operation ----------------
    drive(1, 1'b1, 3'd3, 32'h0000_AAAA, 32'd0);
    step();
    drive(1, 1'b1, 3'd4, 32'h0000_BBBB, 32'd0);
    step();
    chk_hilo("lat3_pre", 1, 32'h0000_AAAA, 32'h0000_BBBB);
    drive(1, 1'b1, 3'd1, 32'd5, 32'd6);
    step();                                     // T
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    step();                                     // T+1, second WAIT cycle follows
    chk("lat3_busy", 64'(busy[1]), 64'd1);
    reset[1] = 1'b1;
    step();                                     // reset edge
    chk_hilo("lat3_abort", 1, 32'd0, 32'd0);
    chk("lat3_abort_busy", 64'(busy[1]), 64'd0);
    chk("lat3_abort_done", 64'(done[1]), 64'd0);
    chk("lat3_abort_ready", 64'(op_ready[1]), 64'd0);
    reset[1] = 1'b0;
    #1;
    chk("lat3_ready_after", 64'(op_ready[1]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lat3_no_done", 64'(done[1]), 64'd0);
      chk("lat3_hi_zero", 64'(hi[1]), 64'd0);
    end

    // ---------------- MUL_LAT = 1: minimum latency, back-to-back ----------------
    drive(2, 1'b1, 3'd2, 32'h8000_0000, 32'h0000_0002);
    step();                                     // T
    chk("lat1_busy", 64'(busy[2]), 64'd1);
    drive(2, 1'b1, 3'd1, 32'h0000_0007, 32'hFFFF_FFFD);
    step();                                     // T+1 commit, MULT held
    chk_hilo("lat1_multu", 2, 32'h0000_0001, 32'h0000_0000);
    chk("lat1_done", 64'(done[2]), 64'd1);
    chk("lat1_ready_in_done", 64'(op_ready[2]), 64'd1);
    step();                                     // MULT accepted in done cycle
    drive(2, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("lat1_b2b_busy", 64'(busy[2]), 64'd1);
    chk("lat1_b2b_done_clr", 64'(done[2]), 64'd0);
    step();
    chk_hilo("lat1_mult", 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    chk("lat1_done2", 64'(done[2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mul_ctrl.md
Name: hilo_mul_ctrl

Overview:
- Multi-cycle issue controller and HI/LO register pair that sits directly downstream of the CPU's combinational 32x32 signed multiplier.
- Accepts MULT, MULTU, MTHI and MTLO from decode and drives the multiplier operands.
- Waits a fixed settle time (multicycle path), samples the 64-bit product, applies the unsigned correction for MULTU, and commits the result to HI/LO.
- Exposes HI/LO to the MFHI/MFLO datapath, and a busy flag that stalls the pipeline.

Parameters:
- MUL_LAT, default 2: cycles allowed for the multiplier product to settle. Legal range is 1..15; any other value must fail an elaboration-time check.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  operation request from decode
- op_code  in  3  0=NOP, 1=MULT, 2=MULTU, 3=MTHI, 4=MTLO; 5..7 are treated as NOP
- rs_val  in  32  rs operand (multiplicand, or MTHI/MTLO data)
- rt_val  in  32  rt operand (multiplier)
- op_ready  out  1  controller can accept an operation
- mul_a  out  32  registered operand to the external multiplier
- mul_b  out  32  registered operand to the external multiplier
- mul_z  in  64  signed product returned by the multiplier
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  multiply in flight; pipeline stalls MFHI/MFLO/MULT*
- done  out  1  one-cycle pulse in the cycle after a multiply commits

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, hi=0, lo=0, mul_a=0, mul_b=0, cnt=0, uns=0, done=0, busy=0.
  - op_ready is 0 while reset is high.
  - Reset during WAIT aborts the operation: no HI/LO write and no done pulse.
- Outputs:
  - op_ready = (state==IDLE) & ~reset.
  - busy = (state==WAIT).
- Accept condition: op_valid & op_ready at a rising edge T.
- State IDLE:
  - On accept with MULT/MULTU: mul_a<=rs_val, mul_b<=rt_val, uns<=(op_code==MULTU), cnt<=MUL_LAT-1, state->WAIT.
  - On accept with MTHI: hi<=rs_val at edge T; lo is unchanged; state stays IDLE.
  - On accept with MTLO: lo<=rs_val at edge T; hi is unchanged.
  - On accept with NOP or codes 5..7: no state change.
- State WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: {hi,lo}<=prod at this edge, done<=1, state->IDLE.
- Latency:
  - HI/LO update at edge T+MUL_LAT.
  - busy is high from T+ through T+MUL_LAT.
  - done is high for the cycle following edge T+MUL_LAT.
- done is cleared at every edge where it is not being set.
- mul_a and mul_b hold their values after commit until the next multiply is accepted.
- op_valid while busy is ignored. Decode must hold the request; it is not queued.
- Arithmetic (all modulo 2^64):
  - MULT: prod = mul_z.
  - MULTU: prod = mul_z + (mul_a[31] ? {mul_b,32'b0} : 0) + (mul_b[31] ? {mul_a,32'b0} : 0).
  - This converts the signed product to the unsigned product.
- A back-to-back MULT may be accepted in the cycle done is high (state is IDLE then).

Decomposition:
- Shared package (cpu_muldiv_pkg):
  - op_code localparams OP_NOP, OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO.
  - State enum {IDLE, WAIT}.
  - CNT_W=4.
- One natural sub-module: hilo_unsigned_fix, a purely combinational block.
  - Inputs: mul_z, mul_a, mul_b, uns.
  - Output: prod.
  - Unit-tested separately against a 64-bit reference product.

Test Plan:
- MUL_LAT=2, MULT rs=0xFFFFFFFE rt=0x00000003 -> busy 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+2; done pulses once.
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF (mul_z=1) -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with MULT -> hi=0, lo=1.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next edge, lo unchanged, busy stays 0. Then MTLO 0xCAFEF00D -> lo updated, hi unchanged.
- MULT accepted, then op_valid held with MTLO 0xDEAD during WAIT -> op_ready=0 and lo not written until commit. The MTLO is accepted the cycle after commit and overwrites lo with 0xDEAD.
- Reset asserted in the second WAIT cycle of a MULT (MUL_LAT=3) -> next edge hi=lo=0, state IDLE, done never pulses, op_ready=1 after reset drops.
- MUL_LAT=1, MULTU rs=0x80000000 rt=0x00000002 -> hi=0x00000001, lo=0x00000000 one edge after accept; back-to-back MULT 7x-3 accepted in the done cycle -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
